fetch_pc_gen: RTL
=================

# fetch_pc_gen

Instruction-fetch front end that owns the program counter and drives the instruction memory address every cycle. It predicts the next PC with a 2-bit-counter branch history table plus a direct-mapped branch target buffer, and accepts stalls from the hazard unit and redirects from the execute stage. The PC and prediction outputs travel with the fetched instruction into the IF/ID pipeline register.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `IDX_BITS`, 4, log2 of BHT/BTB entries (16); index is `pc[IDX_BITS+1:2]`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard unit: hold PC, no fetch advance.
- `ex_redirect`  in  1  execute detected misprediction; fetch must restart at `ex_redirect_pc`.
- `ex_redirect_pc`  in  32  correct next PC; bits [1:0] ignored (forced 0).
- `ex_upd_valid`  in  1  a resolved control-flow instruction is reported this cycle.
- `ex_upd_pc`  in  32  PC of that instruction.
- `ex_upd_taken`  in  1  actual outcome (1 for JAL/JALR).
- `ex_upd_target`  in  32  actual taken target.
- `pc`  out  32  current fetch address to instruction memory (registered).
- `pred_taken`  out  1  prediction for instruction at `pc` (combinational from `pc` and table state).
- `pred_target`  out  32  predicted next PC: BTB target if `pred_taken`, else `pc+4`.
- `flush`  out  1  equals `ex_redirect`; IF/ID register loads a bubble.
- `br_count`  out  32  resolved control-flow instructions since reset.
- `mispred_count`  out  32  redirects since reset.

## Operation
- Next-PC priority: `rst` → `RESET_PC`; else `ex_redirect` → `{ex_redirect_pc[31:2],2'b00}`; else `stall` → hold; else `pred_target`.
- Redirect overrides stall in the same cycle.
- BHT: 2^IDX_BITS 2-bit saturating counters, states SNT=00, WNT=01, WT=10, ST=11. Reset all to WNT.
- BTB: per entry valid bit, tag `pc[31:IDX_BITS+2]`, 30-bit target (word address). Reset clears all valid bits; tag/target contents don't care.
- Lookup: hit = valid[idx] && tag match. `pred_taken` = hit && counter[idx][1].
- Update on `ex_upd_valid` (independent of `stall`, not gated by `ex_redirect`): counter at `ex_upd_pc` index increments if taken (saturate at ST), decrements if not (saturate at SNT). If taken, BTB entry written: valid=1, tag, target. Not-taken never invalidates BTB.
- Read-before-write: lookup and update to the same index in one cycle → lookup sees pre-update state; update visible next cycle.
- Counter aliasing between PCs sharing an index is accepted; BHT is untagged.
- `br_count` increments on `ex_upd_valid`; `mispred_count` increments on `ex_redirect`; both wrap 2^32−1 → 0.

## Timing
- Reset values: `pc`=`RESET_PC`, `flush`=0 (while `ex_redirect`=0), `br_count`=0, `mispred_count`=0, `pred_taken`=0 (BTB empty), `pred_target`=`RESET_PC+4`.
- `pc` changes only at rising edge; memory read is combinational, so instruction, `pc`, `pred_taken`, `pred_target` are valid together in the same cycle.
- Redirect latency: `ex_redirect` high in cycle N → `pc`=`ex_redirect_pc` in N+1; `flush` high in N only.
- Table update in cycle N affects prediction from cycle N+1.
- `rst` asserted mid-operation: all state reinitialised at next edge regardless of `stall`/`ex_redirect`/update inputs.
- `pc+4` wraps 32'hFFFF_FFFC → 0.

## Structure
- Shared package `riscv_pkg`: BHT state constants (SNT/WNT/WT/ST), `XLEN`=32, reset-PC default.
- One sub-module `branch_predictor`: BHT + BTB arrays, combinational lookup port, synchronous update port, reset init. `fetch_pc_gen` holds PC register, next-PC mux, perf counters.

## Test plan
- Reset then free-run 4 cycles, no stall/update → `pc` = 0,4,8,12; `pred_taken`=0 throughout.
- `stall`=1 for 3 cycles at `pc`=8 → `pc` stays 8; then `ex_redirect`=1, `ex_redirect_pc`=0x40 with `stall`=1 → `pc`=0x40 next cycle, `flush`=1 that cycle.
- Two updates `ex_upd_pc`=0x10, taken, target 0x80 → counter WNT→WT→ST; next fetch of 0x10 gives `pred_taken`=1, `pred_target`=0x80; three not-taken updates → ST→SNT, `pred_taken`=0, `pred_target`=0x14.
- Aliasing: train 0x10 taken→0x80, then fetch 0x50 (same index, different tag) → `pred_taken`=0, `pred_target`=0x54.
- Update and lookup of 0x10 in same cycle (counter WNT, taken) → that cycle `pred_taken`=0; following cycle 1.
- 5 updates with 2 redirects, then `rst` mid-stream → `br_count`=5, `mispred_count`=2 before; after reset edge all zero, `pc`=`RESET_PC`, BTB empty.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 front-end types: XLEN, reset-PC default and 2-bit BHT counter states.
// Pure declarations plus one combinational helper; no timing or backpressure.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  function automatic bht_state_t bht_next(input bht_state_t s, input logic taken);
    if (taken) begin
      return (s == ST) ? ST : bht_state_t'(s + 2'd1);
    end
    return (s == SNT) ? SNT : bht_state_t'(s - 2'd1);
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Execute/hazard-to-fetch control and fetch-to-IF/ID outputs of the PC generator.
// Fetch advances every cycle unless stall; redirect and table updates are single-cycle strobes.
interface fetch_pc_gen_if;
  import riscv_pkg::*;

  logic            stall;
  logic            ex_redirect;
  logic [XLEN-1:0] ex_redirect_pc;
  logic            ex_upd_valid;
  logic [XLEN-1:0] ex_upd_pc;
  logic            ex_upd_taken;
  logic [XLEN-1:0] ex_upd_target;

  logic [XLEN-1:0] pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            flush;
  logic [XLEN-1:0] br_count;
  logic [XLEN-1:0] mispred_count;

  modport master (
    output stall, ex_redirect, ex_redirect_pc,
    output ex_upd_valid, ex_upd_pc, ex_upd_taken, ex_upd_target,
    input  pc, pred_taken, pred_target, flush, br_count, mispred_count
  );

  modport slave (
    input  stall, ex_redirect, ex_redirect_pc,
    input  ex_upd_valid, ex_upd_pc, ex_upd_taken, ex_upd_target,
    output pc, pred_taken, pred_target, flush, br_count, mispred_count
  );

endinterface

// File: rtl/branch_predictor.sv
// Untagged 2-bit BHT plus direct-mapped tagged BTB; combinational lookup, synchronous update.
// Lookup is 0-cycle; an update becomes visible to lookups from the next cycle. No backpressure.
module branch_predictor
  import riscv_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_lk_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  input  logic            i_upd_vld,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  input  logic [XLEN-1:0] i_upd_target
);

  localparam int NENT  = 1 << IDX_BITS;
  localparam int TAG_W = XLEN - IDX_BITS - 2;

  logic [1:0]      r_bht     [NENT];
  logic [NENT-1:0] r_btb_vld;
  logic [TAG_W-1:0] r_btb_tag [NENT];
  logic [XLEN-3:0] r_btb_tgt [NENT];

  logic [IDX_BITS-1:0] w_lk_idx, w_up_idx;
  logic [TAG_W-1:0]    w_lk_tag, w_up_tag;
  logic                w_hit;
  logic                w_unused_lsb;

  assign w_lk_idx = i_lk_pc[IDX_BITS+1:2];
  assign w_lk_tag = i_lk_pc[XLEN-1:IDX_BITS+2];
  assign w_up_idx = i_upd_pc[IDX_BITS+1:2];
  assign w_up_tag = i_upd_pc[XLEN-1:IDX_BITS+2];
  assign w_unused_lsb = ^{i_upd_pc[1:0], i_upd_target[1:0]};

  // Reads use the registered arrays only, so a same-cycle update is not seen here.
  assign w_hit         = r_btb_vld[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
  assign o_pred_taken  = w_hit && r_bht[w_lk_idx][1];
  assign o_pred_target = o_pred_taken ? {r_btb_tgt[w_lk_idx], 2'b00} : i_lk_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NENT; i++) begin
        r_bht[i] <= WNT;
      end
      r_btb_vld <= '0;
    end else if (i_upd_vld) begin
      r_bht[w_up_idx] <= bht_next(bht_state_t'(r_bht[w_up_idx]), i_upd_taken);
      if (i_upd_taken) begin
        r_btb_vld[w_up_idx] <= 1'b1;
      end
    end
  end

  // Tag/target payload is qualified by the valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!rst && i_upd_vld && i_upd_taken) begin
      r_btb_tag[w_up_idx] <= w_up_tag;
      r_btb_tgt[w_up_idx] <= i_upd_target[XLEN-1:2];
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC register with predicted next-PC mux, execute redirect and perf counters.
// Redirect lands next cycle and overrides stall; stall holds the PC; flush is combinational.
module fetch_pc_gen
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              IDX_BITS = 4
) (
  input  logic           clk,
  input  logic           rst,
  fetch_pc_gen_if.slave  bus
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_br_cnt;
  logic [XLEN-1:0] r_mis_cnt;

  logic            w_pred_taken;
  logic [XLEN-1:0] w_pred_target;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_unused_redir_lsb;

  assign w_redir_pc         = {bus.ex_redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_redir_lsb = ^bus.ex_redirect_pc[1:0];

  branch_predictor #(
    .IDX_BITS (IDX_BITS)
  ) u_bp (
    .clk           (clk),
    .rst           (rst),
    .i_lk_pc       (r_pc),
    .o_pred_taken  (w_pred_taken),
    .o_pred_target (w_pred_target),
    .i_upd_vld     (bus.ex_upd_valid),
    .i_upd_pc      (bus.ex_upd_pc),
    .i_upd_taken   (bus.ex_upd_taken),
    .i_upd_target  (bus.ex_upd_target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (bus.ex_redirect) begin
      r_pc <= w_redir_pc;
    end else if (!bus.stall) begin
      r_pc <= w_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (bus.ex_upd_valid) r_br_cnt  <= r_br_cnt + 32'd1;
      if (bus.ex_redirect)  r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  assign bus.pc            = r_pc;
  assign bus.pred_taken    = w_pred_taken;
  assign bus.pred_target   = w_pred_target;
  assign bus.flush         = bus.ex_redirect;
  assign bus.br_count      = r_br_cnt;
  assign bus.mispred_count = r_mis_cnt;

endmodule
